i2c_dri: RTL and testbench

I2C_DRI -- requirements
Module: i2c_dri

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_tick_gen.sv | 38 +++
 rtl/i2c_dri.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_i2c_dri.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the i2c_dri master: FSM state encoding, bit timing and R/W bit values.
package i2c_pkg;

   localparam int unsigned TICKS_PER_BIT = 4;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_START   = 4'd1;
   localparam logic [3:0] ST_DEV_W   = 4'd2;
   localparam logic [3:0] ST_ADDR_HI = 4'd3;
   localparam logic [3:0] ST_ADDR_LO = 4'd4;
   localparam logic [3:0] ST_DATA_WR = 4'd5;
   localparam logic [3:0] ST_RESTART = 4'd6;
   localparam logic [3:0] ST_DEV_R   = 4'd7;
   localparam logic [3:0] ST_DATA_RD = 4'd8;
   localparam logic [3:0] ST_STOP    = 4'd9;

   // Tick slots within one SCL bit.
   localparam logic [1:0] PH_LOW    = 2'd0;
   localparam logic [1:0] PH_SET    = 2'd1;
   localparam logic [1:0] PH_HIGH   = 2'd2;
   localparam logic [1:0] PH_SAMPLE = 2'd3;

   function automatic logic is_byte_state(input logic [3:0] s);
      return (s == ST_DEV_W)   || (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
             (s == ST_DATA_WR) || (s == ST_DEV_R)   || (s == ST_DATA_RD);
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Tick divider: one-cycle tick every CLK_FREQ/(TICKS_PER_BIT*I2C_FREQ) clk cycles; clr holds it at zero.
module i2c_tick_gen
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned I2C_FREQ = 250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned DIV_RAW = CLK_FREQ / (TICKS_PER_BIT * I2C_FREQ);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/i2c_dri.sv
// i2c_dri: single-byte I2C master (write, or read with repeated START) behind a word address.
// Define I2C_ADDR16_EN to add the ADDR_HI phase selected by bit_ctrl.
module i2c_dri
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = 7'b1001000,
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned I2C_FREQ   = 250_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i2c_exec,
   input  logic        i2c_rh_wl,
   input  logic [15:0] i2c_addr,
   input  logic [7:0]  i2c_data_w,
   input  logic        bit_ctrl,
   output logic [7:0]  i2c_data_r,
   output logic        i2c_done,
   output logic        i2c_ack,
   output logic        busy,
   output logic        scl,
   output logic        sda_out,
   output logic        sda_oe,
   input  logic        sda_in
);

   logic [3:0] state_q,   state_d;
   logic [1:0] phase_q,   phase_d;
   logic [3:0] bit_q,     bit_d;
   logic [7:0] shift_q,   shift_d;
   logic [7:0] rx_q,      rx_d;
   logic       rh_wl_q,   rh_wl_d;
   logic [7:0] addr_lo_q, addr_lo_d;
   logic [7:0] data_w_q,  data_w_d;
   logic       scl_q,     scl_d;
   logic       sda_out_q, sda_out_d;
   logic       sda_oe_q,  sda_oe_d;
   logic       done_q,    done_d;
   logic       ack_q,     ack_d;
   logic       busy_q,    busy_d;
   logic [7:0] data_r_q,  data_r_d;
`ifdef I2C_ADDR16_EN
   logic [7:0] addr_hi_q, addr_hi_d;
   logic       bit_ctrl_q, bit_ctrl_d;
`else
   logic       unused_addr16;
   assign unused_addr16 = ^{bit_ctrl, i2c_addr[15:8]};
`endif

   logic       tick;
   logic [3:0] nxt_state;
   logic [7:0] nxt_byte;

   i2c_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .I2C_FREQ (I2C_FREQ)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q == ST_IDLE),
      .tick (tick)
   );

   // Successor state and byte to load once the current byte has been ACKed.
   always_comb begin
      nxt_state = ST_STOP;
      nxt_byte  = '0;
      case (state_q)
         ST_DEV_W: begin
`ifdef I2C_ADDR16_EN
            if (bit_ctrl_q) begin
               nxt_state = ST_ADDR_HI;
               nxt_byte  = addr_hi_q;
            end else begin
               nxt_state = ST_ADDR_LO;
               nxt_byte  = addr_lo_q;
            end
`else
            nxt_state = ST_ADDR_LO;
            nxt_byte  = addr_lo_q;
`endif
         end
`ifdef I2C_ADDR16_EN
         ST_ADDR_HI: begin
            nxt_state = ST_ADDR_LO;
            nxt_byte  = addr_lo_q;
         end
`endif
         ST_ADDR_LO: begin
            if (rh_wl_q == RW_READ) begin
               nxt_state = ST_RESTART;
            end else begin
               nxt_state = ST_DATA_WR;
               nxt_byte  = data_w_q;
            end
         end
         ST_DEV_R: nxt_state = ST_DATA_RD;
         default:  ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_d      = rx_q;
      rh_wl_d   = rh_wl_q;
      addr_lo_d = addr_lo_q;
      data_w_d  = data_w_q;
      scl_d     = scl_q;
      sda_out_d = sda_out_q;
      sda_oe_d  = sda_oe_q;
      done_d    = 1'b0;
      ack_d     = ack_q;
      busy_d    = busy_q;
      data_r_d  = data_r_q;
`ifdef I2C_ADDR16_EN
      addr_hi_d  = addr_hi_q;
      bit_ctrl_d = bit_ctrl_q;
`endif

      if (state_q == ST_IDLE) begin
         scl_d     = 1'b1;
         sda_out_d = 1'b1;
         sda_oe_d  = 1'b0;
         // done_q blocks the done cycle itself so the next command lands strictly after it.
         if (i2c_exec && !done_q) begin
            state_d   = ST_START;
            phase_d   = '0;
            bit_d     = '0;
            rh_wl_d   = i2c_rh_wl;
            addr_lo_d = i2c_addr[7:0];
            data_w_d  = i2c_data_w;
            busy_d    = 1'b1;
            ack_d     = 1'b0;
`ifdef I2C_ADDR16_EN
            addr_hi_d  = i2c_addr[15:8];
            bit_ctrl_d = bit_ctrl;
`endif
         end
      end else if (tick) begin
         phase_d = phase_q + 2'd1;
         case (state_q)
            ST_START: begin
               case (phase_q)
                  PH_LOW: begin
                     sda_oe_d  = 1'b1;
                     sda_out_d = 1'b1;
                  end
                  PH_HIGH: sda_out_d = 1'b0;
                  PH_SAMPLE: begin
                     state_d = ST_DEV_W;
                     bit_d   = '0;
                     shift_d = {SLAVE_ADDR, RW_WRITE};
                  end
                  default: ;
               endcase
            end
            ST_RESTART: begin
               case (phase_q)
                  PH_LOW: scl_d = 1'b0;
                  PH_SET: begin
                     sda_oe_d  = 1'b1;
                     sda_out_d = 1'b1;
                  end
                  PH_HIGH: scl_d = 1'b1;
                  default: begin
                     sda_out_d = 1'b0;
                     state_d   = ST_DEV_R;
                     bit_d     = '0;
                     shift_d   = {SLAVE_ADDR, RW_READ};
                  end
               endcase
            end
            ST_STOP: begin
               case (phase_q)
                  PH_LOW: scl_d = 1'b0;
                  PH_SET: begin
                     sda_oe_d  = 1'b1;
                     sda_out_d = 1'b0;
                  end
                  PH_HIGH: scl_d = 1'b1;
                  default: begin
                     sda_out_d = 1'b1;
                     sda_oe_d  = 1'b0;
                     state_d   = ST_IDLE;
                     done_d    = 1'b1;
                     busy_d    = 1'b0;
                  end
               endcase
            end
            default: begin
               if (!is_byte_state(state_q)) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  case (phase_q)
                     PH_LOW: scl_d = 1'b0;
                     PH_SET: begin
                        // Bits 0..7 carry data; bit 8 is the ACK slot, released by the master.
                        if (bit_q < 4'd8 && state_q != ST_DATA_RD) begin
                           sda_oe_d  = 1'b1;
                           sda_out_d = shift_q[7];
                        end else begin
                           sda_oe_d  = 1'b0;
                           sda_out_d = 1'b1;
                        end
                     end
                     PH_HIGH: scl_d = 1'b1;
                     default: begin
                        if (bit_q < 4'd8) begin
                           bit_d = bit_q + 4'd1;
                           if (state_q == ST_DATA_RD) begin
                              rx_d = {rx_q[6:0], sda_in};
                           end else begin
                              shift_d = {shift_q[6:0], 1'b0};
                           end
                        end else begin
                           bit_d = '0;
                           if (state_q == ST_DATA_RD) begin
                              data_r_d = rx_q;
                              state_d  = ST_STOP;
                           end else if (sda_in) begin
                              ack_d   = 1'b1;
                              state_d = ST_STOP;
                           end else begin
                              state_d = nxt_state;
                              shift_d = nxt_byte;
                           end
                        end
                     end
                  endcase
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         phase_q   <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_q      <= '0;
         rh_wl_q   <= RW_WRITE;
         addr_lo_q <= '0;
         data_w_q  <= '0;
         scl_q     <= 1'b1;
         sda_out_q <= 1'b1;
         sda_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         data_r_q  <= '0;
`ifdef I2C_ADDR16_EN
         addr_hi_q  <= '0;
         bit_ctrl_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_q      <= rx_d;
         rh_wl_q   <= rh_wl_d;
         addr_lo_q <= addr_lo_d;
         data_w_q  <= data_w_d;
         scl_q     <= scl_d;
         sda_out_q <= sda_out_d;
         sda_oe_q  <= sda_oe_d;
         done_q    <= done_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         data_r_q  <= data_r_d;
`ifdef I2C_ADDR16_EN
         addr_hi_q  <= addr_hi_d;
         bit_ctrl_q <= bit_ctrl_d;
`endif
      end
   end

   assign i2c_data_r = data_r_q;
   assign i2c_done   = done_q;
   assign i2c_ack    = ack_q;
   assign busy       = busy_q;
   assign scl        = scl_q;
   assign sda_out    = sda_out_q;
   assign sda_oe     = sda_oe_q;

endmodule

// File: tb/tb_i2c_dri.sv
// Bench for i2c_dri: behavioural open-drain slave plus a transaction-level expectation model.
module tb_i2c_dri;

   localparam logic [6:0] SADDR    = 7'b1001000;
   localparam int         EV_ACK   = 256;
   localparam int         EV_NACK  = 257;
   localparam int         EV_START = 512;
   localparam int         EV_STOP  = 513;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i2c_exec = 1'b0;
   logic        i2c_rh_wl = 1'b0;
   logic [15:0] i2c_addr = '0;
   logic [7:0]  i2c_data_w = '0;
   logic        bit_ctrl = 1'b0;
   logic [7:0]  i2c_data_r;
   logic        i2c_done, i2c_ack, busy, scl, sda_out, sda_oe, sda_in;
   logic        sda_bus;
   logic        slv_low = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          bus_log[$];
   int          done_cnt = 0;
   int          long_done = 0;
   logic        done_p = 1'b0;
   logic [7:0]  model_data_r = '0;

   // slave model state
   int          slv_cnt = 0;
   int          slv_byte_num = 0;
   int          slv_nack_at = -1;
   logic [7:0]  slv_acc = '0;
   logic [7:0]  slv_rdata = '0;
   logic        slv_first = 1'b0;
   logic        slv_read = 1'b0;
   logic        slv_pend = 1'b0;
   logic        scl_p = 1'b1;
   logic        sda_p = 1'b1;

   assign sda_bus = (sda_oe ? sda_out : 1'b1) & ~slv_low;
   assign sda_in  = sda_bus;

   i2c_dri #(
      .SLAVE_ADDR (SADDR),
      .CLK_FREQ   (4_000_000),
      .I2C_FREQ   (250_000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i2c_exec   (i2c_exec),
      .i2c_rh_wl  (i2c_rh_wl),
      .i2c_addr   (i2c_addr),
      .i2c_data_w (i2c_data_w),
      .bit_ctrl   (bit_ctrl),
      .i2c_data_r (i2c_data_r),
      .i2c_done   (i2c_done),
      .i2c_ack    (i2c_ack),
      .busy       (busy),
      .scl        (scl),
      .sda_out    (sda_out),
      .sda_oe     (sda_oe),
      .sda_in     (sda_in)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Open-drain slave: logs bytes/ACKs/START/STOP, ACKs written bytes, returns slv_rdata on reads.
   task automatic slave_step();
      logic s;
      logic ackit;
      s = sda_bus;
      if (i2c_done) begin
         done_cnt++;
         if (done_p) long_done++;
      end
      done_p = i2c_done;
      if (scl && scl_p && sda_p && !s) begin
         bus_log.push_back(EV_START);
         slv_cnt = 0; slv_first = 1'b1; slv_read = 1'b0; slv_pend = 1'b0; slv_low = 1'b0;
      end else if (scl && scl_p && !sda_p && s) begin
         bus_log.push_back(EV_STOP);
      end else if (busy && scl && !scl_p) begin
         if (slv_cnt < 8) begin
            slv_acc = {slv_acc[6:0], s};
            slv_cnt++;
            if (slv_cnt == 8) begin
               bus_log.push_back(int'(slv_acc));
               slv_byte_num++;
            end
         end else if (slv_cnt == 8) begin
            bus_log.push_back(s ? EV_NACK : EV_ACK);
            if (slv_read && s) slv_pend = 1'b0;
            slv_cnt = 9;
         end
      end else if (busy && !scl && scl_p) begin
         if (slv_cnt == 9) begin
            slv_cnt  = 0;
            slv_read = slv_pend;
         end
         if (slv_cnt == 8) begin
            if (slv_read) begin
               slv_low = 1'b0;
            end else begin
               ackit   = (slv_byte_num - 1) != slv_nack_at;
               slv_low = ackit;
               if (slv_first && slv_acc[0] && ackit) slv_pend = 1'b1;
               slv_first = 1'b0;
            end
         end else begin
            slv_low = slv_read ? ~slv_rdata[7 - slv_cnt] : 1'b0;
         end
      end
      if (!busy) begin
         slv_cnt = 0; slv_byte_num = 0; slv_first = 1'b0;
         slv_read = 1'b0; slv_pend = 1'b0; slv_low = 1'b0;
      end
      scl_p = scl;
      sda_p = s;
   endtask

   initial forever begin
      @(negedge clk);
      slave_step();
   end

   task automatic run_xfer(input bit rw, input bit bc, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd, input int nack, input bit inject, input bit exec_at_done);
      int   base;
      bit   a16;
      bit   got_done;
      bit   nacked;
      int   exp_q[$];
      logic [7:0] bytes[$];
`ifdef I2C_ADDR16_EN
      a16 = bc;
`else
      a16 = 1'b0;
`endif
      // Expected bus trace from the protocol rules alone.
      bytes.push_back({SADDR, 1'b0});
      if (a16) bytes.push_back(addr[15:8]);
      bytes.push_back(addr[7:0]);
      if (!rw) bytes.push_back(wd);
      nacked = 1'b0;
      exp_q.push_back(EV_START);
      for (int i = 0; i < bytes.size(); i++) begin
         exp_q.push_back(int'(bytes[i]));
         if (i == nack) begin
            exp_q.push_back(EV_NACK);
            nacked = 1'b1;
            break;
         end
         exp_q.push_back(EV_ACK);
      end
      if (rw && !nacked) begin
         exp_q.push_back(EV_START);
         exp_q.push_back(int'({SADDR, 1'b1}));
         if (nack == bytes.size()) begin
            exp_q.push_back(EV_NACK);
            nacked = 1'b1;
         end else begin
            exp_q.push_back(EV_ACK);
            exp_q.push_back(int'(rd));
            exp_q.push_back(EV_NACK);
         end
      end
      exp_q.push_back(EV_STOP);
      if (rw && !nacked) model_data_r = rd;

      @(negedge clk);
      slv_rdata   = rd;
      slv_nack_at = nack;
      bus_log.delete();
      base = done_cnt;
      i2c_rh_wl = rw; bit_ctrl = bc; i2c_addr = addr; i2c_data_w = wd; i2c_exec = 1'b1;
      @(negedge clk);
      i2c_exec = 1'b0;
      i2c_rh_wl = ~rw; bit_ctrl = ~bc; i2c_addr = ~addr; i2c_data_w = ~wd;
      check("busy_rise", busy, 1);
      if (inject) begin
         repeat ($urandom_range(20, 150)) @(negedge clk);
         i2c_exec = 1'b1;
         @(negedge clk);
         i2c_exec = 1'b0;
      end
      got_done = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (i2c_done) begin
            got_done = 1'b1;
            break;
         end
      end
      check("done_seen", got_done, 1);
      if (got_done) begin
         check("busy_at_done", busy, 0);
         if (exec_at_done) begin
            i2c_exec = 1'b1;
            @(negedge clk);
            i2c_exec = 1'b0;
            check("exec_in_done_ignored", busy, 0);
         end
      end
      repeat (4) @(negedge clk);
      check("done_pulses", done_cnt - base, 1);
      check("ack", i2c_ack, nacked);
      check("data_r", i2c_data_r, model_data_r);
      check("log_len", bus_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
         check($sformatf("ev%0d", i), bus_log[i], exp_q[i]);
      end
   endtask

   task automatic reset_mid_write();
      bit hit;
      int nstop;
      @(negedge clk);
      slv_nack_at = -1;
      bus_log.delete();
      i2c_rh_wl = 1'b0; bit_ctrl = 1'b0; i2c_addr = 16'h0040; i2c_data_w = 8'hC3; i2c_exec = 1'b1;
      @(negedge clk);
      i2c_exec = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (busy && slv_byte_num == 2 && slv_cnt == 3 && !scl) begin
            hit = 1'b1;
            break;
         end
      end
      check("rst_point_found", hit, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_data_r = '0;
      check("rst_scl", scl, 1);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_sda_out", sda_out, 1);
      check("rst_busy", busy, 0);
      check("rst_done", i2c_done, 0);
      check("rst_ack", i2c_ack, 0);
      check("rst_data_r", i2c_data_r, 0);
      repeat (200) @(negedge clk);
      nstop = 0;
      foreach (bus_log[i]) if (bus_log[i] == EV_STOP) nstop++;
      check("no_stop_on_reset", nstop, 0);
      check("idle_after_reset", {scl, busy}, 2'b10);
   endtask

   initial begin
      bit   rw, bc, a16r;
      int   nb, nk;
      repeat (3) @(negedge clk);
      check("reset_scl", scl, 1);
      check("reset_sda_oe", sda_oe, 0);
      check("reset_busy", busy, 0);
      check("reset_done", i2c_done, 0);
      check("reset_ack", i2c_ack, 0);
      check("reset_data_r", i2c_data_r, 0);
      rst = 1'b0;

      run_xfer(1'b0, 1'b0, 16'h0040, 8'h5A, 8'h00, -1, 1'b0, 1'b1);
      run_xfer(1'b1, 1'b0, 16'h0040, 8'h00, 8'hA5, -1, 1'b0, 1'b0);
      run_xfer(1'b0, 1'b0, 16'h0040, 8'h5A, 8'h00,  0, 1'b0, 1'b0);
      run_xfer(1'b1, 1'b0, 16'h0022, 8'h00, 8'h3C,  2, 1'b0, 1'b0);
      run_xfer(1'b0, 1'b0, 16'h0011, 8'h3C, 8'h00, -1, 1'b1, 1'b0);
      reset_mid_write();
      run_xfer(1'b0, 1'b0, 16'h0040, 8'h5A, 8'h00, -1, 1'b0, 1'b0);
      run_xfer(1'b0, 1'b1, 16'h1234, 8'h77, 8'h00, -1, 1'b0, 1'b0);
      run_xfer(1'b1, 1'b1, 16'hBEEF, 8'h00, 8'h69, -1, 1'b0, 1'b0);

      for (int t = 0; t < 10; t++) begin
         rw = 1'($urandom_range(0, 1));
         bc = 1'($urandom_range(0, 1));
`ifdef I2C_ADDR16_EN
         a16r = bc;
`else
         a16r = 1'b0;
`endif
         nb = 3 + int'(a16r);
         nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
         run_xfer(rw, bc, 16'($urandom), 8'($urandom), 8'($urandom), nk,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
      end

      check("done_width", long_done, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
